romupload: RTL and testbench
============================

Name: romupload

Overview:
- Upload manager for ioctl save/dump transfers. It is the read-direction counterpart of the ROM download path.
- On each host read strobe it decodes the menu index and address, then fetches one byte from boot, CHR or cart memory through a req/ack read port.
- It stalls the host with IOCTL_WAIT until the byte is on IOCTL_DIN.
- It sits between the hps_io ioctl bus and the memory arbiter in the system top level.

Parameters:
- TIMEOUT, 64: maximum cycles to wait for MEMRD_ACK before substituting 8'hFF. Range 2..255.

Ports:
- CLK_SYS  in  1  system clock; all logic is on its rising edge
- RESET  in  1  asynchronous, active-high reset
- IOCTL_UPLOAD  in  1  host upload session active
- IOCTL_INDEX  in  16  [5:0] menusub: 0 = boot+CHR image, 1 = cart
- IOCTL_RD  in  1  one-cycle read strobe from host
- IOCTL_ADDR  in  27  byte address of the read
- IOCTL_DIN  out  8  read data returned to host
- IOCTL_WAIT  out  1  host stall
- MEMRD_SEL_BOOT  out  1  target is the boot ROM (4 KiB)
- MEMRD_SEL_CHR  out  1  target is the CHR ROM (1 KiB)
- MEMRD_SEL_CART  out  1  target is cart memory (128 KiB)
- MEMRD_ADDR  out  17  memory byte address
- MEMRD_REQ  out  1  read request, held until ack
- MEMRD_ACK  in  1  one-cycle ack; MEMRD_DATA is valid in the same cycle
- MEMRD_DATA  in  8  memory read data
- TIMEOUT_ERR  out  1  sticky flag: at least one read timed out in this session

Behaviour:
- Reset values: IOCTL_DIN = 0; IOCTL_WAIT = 0; all MEMRD_SEL_* = 0; MEMRD_ADDR = 0; MEMRD_REQ = 0; TIMEOUT_ERR = 0; state = IDLE; timeout counter = 0.
- Address decode happens once, on the accepted IOCTL_RD:
  - menusub 0, ADDR < 24'h1000: BOOT, MEMRD_ADDR = {5'b0, ADDR[11:0]}.
  - menusub 0, 24'h1000 <= ADDR < 24'h1400: CHR, MEMRD_ADDR = {7'b0, ADDR[9:0]}.
  - menusub 1: CART, MEMRD_ADDR = ADDR[16:0]. Higher address bits are ignored, so the address wraps at 128 KiB.
  - Any other index, or menusub 0 with ADDR >= 24'h1400: UNMAPPED.
- IDLE:
  - IOCTL_RD & IOCTL_UPLOAD, mapped: register selects and address, MEMRD_REQ = 1, IOCTL_WAIT = 1 from the next cycle, go to FETCH.
  - IOCTL_RD & IOCTL_UPLOAD, unmapped: next cycle IOCTL_DIN = 8'hFF, IOCTL_WAIT stays 0, stay in IDLE.
  - IOCTL_RD without IOCTL_UPLOAD: ignored.
- FETCH:
  - MEMRD_REQ, selects and address are held stable. The counter increments every cycle.
  - MEMRD_ACK: latch MEMRD_DATA into IOCTL_DIN. Next cycle MEMRD_REQ = 0, IOCTL_WAIT = 0, selects = 0, go to IDLE.
  - Counter reaches TIMEOUT-1 with no ack: IOCTL_DIN = 8'hFF, TIMEOUT_ERR = 1, drop REQ and WAIT, go to IDLE.
  - An ack on the expiry cycle wins: the real data is returned and no error is flagged.
- Latency: if the ack arrives N cycles after REQ rises (N >= 0), WAIT is high for N+1 cycles and IOCTL_DIN updates in the same cycle WAIT falls. Minimum stall is 1 cycle.
- IOCTL_RD arriving while in FETCH is ignored and does not restart the fetch.
- IOCTL_UPLOAD falling while in FETCH aborts the read:
  - Next cycle MEMRD_REQ = 0, WAIT = 0, selects = 0, state = IDLE.
  - IOCTL_DIN holds its previous value.
  - An ack arriving in the abort cycle is discarded.
- TIMEOUT_ERR clears on the rising edge of IOCTL_UPLOAD (registered edge detect) and otherwise holds.
- Asynchronous RESET mid-fetch returns every output to its reset value immediately. A memory arbiter still holding an ack is tolerated, because ack in IDLE is ignored.
- At most one of MEMRD_SEL_* is high at any time, and only while MEMRD_REQ = 1.

Optional Feature:
- Macro ROMUPLOAD_CKSUM_EN.
- Defined: adds output CKSUM [15:0], reset to 0.
  - Cleared on the rising edge of IOCTL_UPLOAD.
  - Every byte delivered to IOCTL_DIN (acked data, timeout 8'hFF, unmapped 8'hFF) is added modulo 2^16, in the cycle IOCTL_DIN updates.
  - Aborted reads add nothing.
- Undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
1. Boot read: index 0, RD at ADDR 27'h0123, ack with 8'hA5 three cycles after REQ -> MEMRD_SEL_BOOT = 1, MEMRD_ADDR = 17'h00123, WAIT high for 4 cycles, then DIN = 8'hA5 and WAIT = 0.
2. CHR and unmapped: index 0, RD at 27'h13FF -> SEL_CHR = 1, MEMRD_ADDR = 17'h003FF. Then RD at 27'h1400 -> no REQ, WAIT never rises, DIN = 8'hFF.
3. Cart wrap: index 1, RD at 27'h2_0005 -> SEL_CART = 1, MEMRD_ADDR = 17'h00005. A zero-latency ack (ack in the first REQ cycle) -> exactly one WAIT cycle.
4. Timeout: TIMEOUT = 8, no ack -> WAIT high for 8 cycles, DIN = 8'hFF, TIMEOUT_ERR = 1. Toggle IOCTL_UPLOAD 0 -> 1 -> TIMEOUT_ERR = 0.
5. Abort and reset: drop IOCTL_UPLOAD during FETCH, with ack in the same cycle -> REQ/WAIT = 0 next cycle and DIN unchanged. Assert RESET mid-fetch -> all outputs 0 asynchronously. An extra RD during FETCH -> ignored.
6. With ROMUPLOAD_CKSUM_EN: cart reads returning 8'hFF, 8'h02, 8'h10 -> CKSUM = 16'h0111. A new session -> CKSUM = 0.

Source files
------------

// File: rtl/romupload.sv
// rtl/romupload.sv - ioctl upload read path: decodes host reads and fetches bytes via req/ack memory port
// Optional feature macro: ROMUPLOAD_CKSUM_EN adds a running 16-bit CKSUM of delivered bytes.
module romupload #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK_SYS,
    input  logic        RESET,
    input  logic        IOCTL_UPLOAD,
    input  logic [15:0] IOCTL_INDEX,
    input  logic        IOCTL_RD,
    input  logic [26:0] IOCTL_ADDR,
    output logic [7:0]  IOCTL_DIN,
    output logic        IOCTL_WAIT,
    output logic        MEMRD_SEL_BOOT,
    output logic        MEMRD_SEL_CHR,
    output logic        MEMRD_SEL_CART,
    output logic [16:0] MEMRD_ADDR,
    output logic        MEMRD_REQ,
    input  logic        MEMRD_ACK,
    input  logic [7:0]  MEMRD_DATA,
    output logic        TIMEOUT_ERR
`ifdef ROMUPLOAD_CKSUM_EN
    ,
    output logic [15:0] CKSUM
`endif
);

    typedef enum logic {IDLE, FETCH} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic        upload_d;
    logic        upload_rise;
    logic [5:0]  menusub;
    logic        is_boot, is_chr, is_cart, mapped;
    logic [16:0] dec_addr;
    logic        start, unmapped_rd, got_ack, expire, abort;
    logic        unused_bits;

    assign menusub     = IOCTL_INDEX[5:0];
    assign unused_bits = &{1'b0, IOCTL_INDEX[15:6]};
    assign upload_rise = IOCTL_UPLOAD & ~upload_d;

    always_comb begin
        is_boot  = (menusub == 6'd0) && (IOCTL_ADDR < 27'h1000);
        is_chr   = (menusub == 6'd0) && (IOCTL_ADDR >= 27'h1000) && (IOCTL_ADDR < 27'h1400);
        is_cart  = (menusub == 6'd1);
        mapped   = is_boot | is_chr | is_cart;
        dec_addr = 17'd0;
        if (is_boot)
            dec_addr = {5'b0, IOCTL_ADDR[11:0]};
        else if (is_chr)
            dec_addr = {7'b0, IOCTL_ADDR[9:0]};
        else if (is_cart)
            dec_addr = IOCTL_ADDR[16:0];
    end

    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Abort outranks ack, and ack outranks expiry on the same cycle.
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        unmapped_rd = 1'b0;
        got_ack     = 1'b0;
        expire      = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (IOCTL_RD && IOCTL_UPLOAD) begin
                    if (mapped) begin
                        start      = 1'b1;
                        state_next = FETCH;
                    end else begin
                        unmapped_rd = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (!IOCTL_UPLOAD) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (MEMRD_ACK) begin
                    got_ack    = 1'b1;
                    state_next = IDLE;
                end else if (cnt == LAST_CNT) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET) begin
            IOCTL_DIN      <= 8'd0;
            IOCTL_WAIT     <= 1'b0;
            MEMRD_SEL_BOOT <= 1'b0;
            MEMRD_SEL_CHR  <= 1'b0;
            MEMRD_SEL_CART <= 1'b0;
            MEMRD_ADDR     <= 17'd0;
            MEMRD_REQ      <= 1'b0;
            TIMEOUT_ERR    <= 1'b0;
            cnt            <= 8'd0;
            upload_d       <= 1'b0;
        end else begin
            upload_d <= IOCTL_UPLOAD;
            if (start) begin
                MEMRD_SEL_BOOT <= is_boot;
                MEMRD_SEL_CHR  <= is_chr;
                MEMRD_SEL_CART <= is_cart;
                MEMRD_ADDR     <= dec_addr;
                MEMRD_REQ      <= 1'b1;
                IOCTL_WAIT     <= 1'b1;
                cnt            <= 8'd0;
            end else if (state == FETCH) begin
                if (got_ack || expire || abort) begin
                    MEMRD_SEL_BOOT <= 1'b0;
                    MEMRD_SEL_CHR  <= 1'b0;
                    MEMRD_SEL_CART <= 1'b0;
                    MEMRD_REQ      <= 1'b0;
                    IOCTL_WAIT     <= 1'b0;
                    cnt            <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end

            if (got_ack)
                IOCTL_DIN <= MEMRD_DATA;
            else if (expire || unmapped_rd)
                IOCTL_DIN <= 8'hFF;

            if (upload_rise)
                TIMEOUT_ERR <= 1'b0;
            else if (expire)
                TIMEOUT_ERR <= 1'b1;
        end
    end

`ifdef ROMUPLOAD_CKSUM_EN
    logic [7:0]  deliver_byte;
    logic        deliver;

    assign deliver      = got_ack | expire | unmapped_rd;
    assign deliver_byte = got_ack ? MEMRD_DATA : 8'hFF;

    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET)
            CKSUM <= 16'd0;
        else
            CKSUM <= (upload_rise ? 16'd0 : CKSUM) + (deliver ? {8'd0, deliver_byte} : 16'd0);
    end
`endif

endmodule

// File: tb/tb_romupload.sv
// tb/tb_romupload.sv - directed vector bench for romupload (TIMEOUT = 8)
module tb_romupload;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        upload;
    logic [15:0] index;
    logic        rd;
    logic [26:0] addr;
    logic [7:0]  din;
    logic        wait_o;
    logic        sel_boot, sel_chr, sel_cart;
    logic [16:0] maddr;
    logic        req;
    logic        ack;
    logic [7:0]  mdata;
    logic        terr;
`ifdef ROMUPLOAD_CKSUM_EN
    logic [15:0] cksum;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    romupload #(.TIMEOUT(TO)) dut (
        .CLK_SYS       (clk),
        .RESET         (rst),
        .IOCTL_UPLOAD  (upload),
        .IOCTL_INDEX   (index),
        .IOCTL_RD      (rd),
        .IOCTL_ADDR    (addr),
        .IOCTL_DIN     (din),
        .IOCTL_WAIT    (wait_o),
        .MEMRD_SEL_BOOT(sel_boot),
        .MEMRD_SEL_CHR (sel_chr),
        .MEMRD_SEL_CART(sel_cart),
        .MEMRD_ADDR    (maddr),
        .MEMRD_REQ     (req),
        .MEMRD_ACK     (ack),
        .MEMRD_DATA    (mdata),
        .TIMEOUT_ERR   (terr)
`ifdef ROMUPLOAD_CKSUM_EN
        ,
        .CKSUM         (cksum)
`endif
    );

    typedef struct {
        logic [15:0] idx;
        logic [26:0] addr;
        int          delay;
        logic [7:0]  data;
        logic [2:0]  sel;
        logic [16:0] maddr;
        int          waits;
        logic [7:0]  din;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [15:0] i, input logic [26:0] a, input int delay,
                           input logic [7:0] d, output logic [2:0] s, output logic [16:0] ma,
                           output logic rq, output int waits);
        @(negedge clk);
        index = i; addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        s  = {sel_boot, sel_chr, sel_cart};
        ma = maddr;
        rq = req;
        waits = 0;
        while (wait_o && waits < 40) begin
            if (waits == delay) begin
                ack = 1'b1; mdata = d;
            end
            waits++;
            @(negedge clk);
            ack = 1'b0;
        end
    endtask

    logic [2:0]  s;
    logic [16:0] ma;
    logic        rq;
    int          w;

    initial begin
        rst = 1'b1; upload = 1'b0; index = 16'd0; rd = 1'b0; addr = 27'd0;
        ack = 1'b0; mdata = 8'd0;

        vecs[0] = '{16'd0, 27'h0123,  3, 8'hA5, 3'b100, 17'h00123, 4, 8'hA5, 1'b0};
        vecs[1] = '{16'd0, 27'h13FF,  1, 8'h3C, 3'b010, 17'h003FF, 2, 8'h3C, 1'b0};
        vecs[2] = '{16'd0, 27'h1400,  0, 8'h00, 3'b000, 17'h00000, 0, 8'hFF, 1'b0};
        vecs[3] = '{16'd1, 27'h20005, 0, 8'h5A, 3'b001, 17'h00005, 1, 8'h5A, 1'b0};
        vecs[4] = '{16'd0, 27'h0FFF,  2, 8'h11, 3'b100, 17'h00FFF, 3, 8'h11, 1'b0};
        vecs[5] = '{16'd0, 27'h1000,  0, 8'h22, 3'b010, 17'h00000, 1, 8'h22, 1'b0};
        vecs[6] = '{16'd2, 27'h0000,  0, 8'h00, 3'b000, 17'h00000, 0, 8'hFF, 1'b0};
        vecs[7] = '{16'd1, 27'h1FFFF, 7, 8'h77, 3'b001, 17'h1FFFF, 8, 8'h77, 1'b0};
        vecs[8] = '{16'd1, 27'h0010, 255, 8'h00, 3'b001, 17'h00010, 8, 8'hFF, 1'b1};
        vecs[9] = '{16'd0, 27'h0000,  0, 8'h00, 3'b100, 17'h00000, 1, 8'h00, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_din", din, 8'h00);
        check("reset_wait", wait_o, 1'b0);
        check("reset_sel", {sel_boot, sel_chr, sel_cart}, 3'b000);
        check("reset_addr", maddr, 17'h0);
        check("reset_req", req, 1'b0);
        check("reset_err", terr, 1'b0);
        rst = 1'b0;

        do_read(16'd0, 27'h0123, 0, 8'hEE, s, ma, rq, w);
        check("noupload_req", rq, 1'b0);
        check("noupload_waits", w, 0);
        check("noupload_din", din, 8'h00);

        @(negedge clk);
        upload = 1'b1;
        for (int k = 0; k < 10; k++) begin
            do_read(vecs[k].idx, vecs[k].addr, vecs[k].delay, vecs[k].data, s, ma, rq, w);
            check($sformatf("v%0d_sel", k), s, vecs[k].sel);
            check($sformatf("v%0d_req", k), rq, (vecs[k].sel != 3'b000));
            if (vecs[k].sel != 3'b000)
                check($sformatf("v%0d_maddr", k), ma, vecs[k].maddr);
            check($sformatf("v%0d_waits", k), w, vecs[k].waits);
            check($sformatf("v%0d_din", k), din, vecs[k].din);
            check($sformatf("v%0d_err", k), terr, vecs[k].err);
            check($sformatf("v%0d_sel_idle", k), {sel_boot, sel_chr, sel_cart, req}, 4'b0000);
        end

        // session toggle clears the sticky timeout flag
        @(negedge clk); upload = 1'b0;
        @(negedge clk);
        check("err_held_low", terr, 1'b1);
        upload = 1'b1;
        @(negedge clk);
        check("err_cleared", terr, 1'b0);

        // abort with simultaneous ack
        index = 16'd1; addr = 27'h40; rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        check("abort_req_up", {req, wait_o}, 2'b11);
        @(negedge clk);
        upload = 1'b0; ack = 1'b1; mdata = 8'h99;
        @(negedge clk); ack = 1'b0;
        check("abort_reqwait", {req, wait_o}, 2'b00);
        check("abort_sel", {sel_boot, sel_chr, sel_cart}, 3'b000);
        check("abort_din", din, 8'h00);
        upload = 1'b1;
        @(negedge clk);

        // extra RD during fetch is ignored
        index = 16'd0; addr = 27'h0123; rd = 1'b1;
        @(negedge clk);
        index = 16'd1; addr = 27'h0456;
        @(negedge clk); rd = 1'b0;
        check("xrd_addr", maddr, 17'h00123);
        check("xrd_sel", {sel_boot, sel_chr, sel_cart}, 3'b100);
        check("xrd_wait", wait_o, 1'b1);
        ack = 1'b1; mdata = 8'h6B;
        @(negedge clk); ack = 1'b0;
        check("xrd_din", din, 8'h6B);
        check("xrd_wait_low", wait_o, 1'b0);
        @(negedge clk);
        check("xrd_no_restart", req, 1'b0);

        // asynchronous reset mid-fetch
        index = 16'd1; addr = 27'h5; rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        check("rst_fetch_req", req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_req", req, 1'b0);
        check("rst_async_wait", wait_o, 1'b0);
        check("rst_async_din", din, 8'h00);
        check("rst_async_sel", {sel_boot, sel_chr, sel_cart}, 3'b000);
        check("rst_async_addr", maddr, 17'h0);
        @(negedge clk);
        rst = 1'b0; ack = 1'b1; mdata = 8'hC3;
        @(negedge clk); ack = 1'b0;
        check("rst_stale_ack", {req, wait_o}, 2'b00);
        check("rst_stale_din", din, 8'h00);

`ifdef ROMUPLOAD_CKSUM_EN
        @(negedge clk); upload = 1'b0;
        @(negedge clk); upload = 1'b1;
        @(negedge clk);
        check("cksum_clear", cksum, 16'h0);
        do_read(16'd1, 27'h10, 1, 8'hFF, s, ma, rq, w);
        do_read(16'd1, 27'h11, 0, 8'h02, s, ma, rq, w);
        do_read(16'd1, 27'h12, 2, 8'h10, s, ma, rq, w);
        check("cksum_sum", cksum, 16'h0111);
        @(negedge clk); upload = 1'b0;
        @(negedge clk); upload = 1'b1;
        @(negedge clk);
        check("cksum_new_session", cksum, 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
